ptw: RTL
========

PTW -- requirements
Module: ptw

Interface
REQ-001 The block SHALL have no parameters; Sv39 geometry (3 levels, 4 KiB pages, 8-byte PTEs) SHALL be fixed.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 satp  input  64  live SATP CSR value: mode[63:60], asid[59:44], ppn[43:0].
REQ-005 req_valid  input  1  translation request present.
REQ-006 req_vaddr  input  64  virtual address to translate.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 resp_valid  output  1  one-cycle pulse; result valid.
REQ-009 resp_paddr  output  64  physical address, upper 8 bits zero; 0 when resp_fault=1.
REQ-010 resp_fault  output  1  page fault for the completed request.
REQ-011 mreq_valid  output  1  PTE read request to memory.
REQ-012 mreq_addr  output  64  PTE physical address, 8-byte aligned.
REQ-013 mresp_valid  input  1  PTE data returned for the outstanding read.
REQ-014 mresp_data  input  64  PTE value.
REQ-015 flush  input  1  sfence.vma: invalidate cached translation; no effect on walk state.

Function
REQ-016 States SHALL be IDLE, WALK, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on the edge where req_valid & req_ready; req_vaddr and satp SHALL be captured then, and later satp changes SHALL NOT affect the request.
REQ-018 With satp.mode=0 (bare): IDLE->RESP; resp_paddr=vaddr (upper 8 bits zeroed), fault=0, resp_valid the cycle after acceptance.
REQ-019 With satp.mode=8 and vaddr[63:39] not all equal to vaddr[38]: IDLE->RESP with fault=1, no memory access.
REQ-020 Any other mode value SHALL be treated as bare.
REQ-021 Otherwise IDLE->WALK, level=2, base=satp.ppn.
REQ-022 In WALK: mreq_valid=1, mreq_addr={base,12'b0}+vpn[level]*8, where vpn2=va[38:30], vpn1=va[29:21], vpn0=va[20:12]; addr SHALL stay stable until mresp_valid.
REQ-023 mresp_valid SHALL be honoured only in WALK, including the first WALK cycle; mresp_valid outside WALK SHALL be ignored.
REQ-024 On PTE: V=0, or R=0&W=1 -> RESP with fault.
REQ-025 R|X=1 (leaf): at level 2, pte.ppn[17:0]!=0 -> fault; at level 1, pte.ppn[8:0]!=0 -> fault.
REQ-026 Otherwise a leaf SHALL set resp_paddr = pte.ppn with the low 9*level ppn bits replaced by vaddr bits, concatenated with va[11:0].
REQ-027 A non-leaf at level 0 -> fault.
REQ-028 A non-leaf at level>0 SHALL set base=pte[53:10] and level-=1, remaining in WALK; mreq_valid stays high and the address changes on the next cycle.
REQ-029 RESP SHALL last exactly one cycle with resp_valid=1, then go to IDLE; back-to-back requests SHALL be accepted in the IDLE cycle after RESP.
REQ-030 A/D bits SHALL be neither checked nor updated, and permission (U/W/X vs access type) SHALL NOT be checked.
REQ-031 A flush arriving during WALK SHALL NOT abort the walk.

Reset
REQ-032 While reset=1, at the edge: state=IDLE, level=2, and req_ready=1, resp_valid=0, resp_fault=0, resp_paddr=0, mreq_valid=0, mreq_addr=0 in the next cycle.
REQ-033 Reset mid-walk SHALL abandon the walk with no response; an mresp_valid arriving after reset while in IDLE SHALL be ignored.

Configuration
REQ-034 With PTW_TLB_EN defined: a single entry holds {valid, asid, vpn[26:0], level, ppn}, filled only on a non-faulting Sv39 completion.
REQ-035 A TLB hit SHALL require an Sv39 request with matching asid and vpn under the stored level's mask; it SHALL go IDLE->RESP with no memory access.
REQ-036 flush or reset SHALL clear the entry's valid bit.
REQ-037 Without PTW_TLB_EN: no entry exists, flush is ignored, and every Sv39 request walks.

Verification
REQ-038 satp=0, vaddr 0x8000_1234 -> resp_valid next cycle, paddr 0x8000_1234, fault 0, mreq_valid never 1.
REQ-039 satp=0x8000_0000_0008_0000, vaddr 0x4000_1ABC; return PTEs 0x2000_0401, 0x2000_0801, 0x2004_8CCF -> mreq_addr 0x8000_0008, 0x8000_1000, 0x8000_2008; paddr 0x8012_3ABC, fault 0.
REQ-040 Same satp/vaddr, first PTE 0x2000_04CF (misaligned gigapage) -> one access, fault 1, paddr 0.
REQ-041 Sv39, vaddr 0x0000_0080_0000_0000 -> fault 1 one cycle after accept, no mreq.
REQ-042 Reset asserted during the 2nd PTE wait, then stray mresp_valid -> no resp_valid, req_ready=1, mreq_valid=0.
REQ-043 PTW_TLB_EN: repeat REQ-039 -> paddr 0x8012_3ABC in 1 cycle, no mreq; after flush pulse, repeat -> 3 accesses.

Source files
------------

// File: rtl/ptw_if.sv
// Sv39 page-table-walker bus: request/response, PTE memory port, satp/flush, and FSM debug state.
// valid/ready: a request transfers on a rising edge with req_valid & req_ready; resp_valid is a one-cycle pulse; mreq_valid holds with a stable address until mresp_valid is seen.
interface ptw_if;
  logic [63:0] satp;
  logic        req_valid;
  logic [63:0] req_vaddr;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic        mresp_valid;
  logic [63:0] mresp_data;
  logic        flush;
  logic [1:0]  dbg_state;

  modport master (
    output satp, req_valid, req_vaddr, mresp_valid, mresp_data, flush,
    input  req_ready, resp_valid, resp_paddr, resp_fault, mreq_valid, mreq_addr, dbg_state
  );

  modport slave (
    input  satp, req_valid, req_vaddr, mresp_valid, mresp_data, flush,
    output req_ready, resp_valid, resp_paddr, resp_fault, mreq_valid, mreq_addr, dbg_state
  );
endinterface

// File: rtl/ptw.sv
// Sv39 hardware page-table walker (3 levels, 4 KiB pages, 8-byte PTEs), one request at a time.
// Define PTW_TLB_EN to add a single-entry translation cache cleared by flush or reset.
module ptw (
  input  logic clk,
  input  logic reset,
  ptw_if.slave bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WALK      = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic [3:0] MODE_SV39 = 4'd8;

  logic [1:0]  state;
  logic [1:0]  level;
  logic [43:0] base;
  logic [38:0] va;
  logic [63:0] paddr_q;
  logic        fault_q;

  // Leaf translation: low 9*lvl PPN bits come from the virtual address.
  function automatic logic [55:0] leaf_pa(input logic [43:0] ppn, input logic [1:0] lvl,
                                          input logic [29:0] v);
    case (lvl)
      2'd2:    leaf_pa = {ppn[43:18], v[29:0]};
      2'd1:    leaf_pa = {ppn[43:9], v[20:0]};
      default: leaf_pa = {ppn, v[11:0]};
    endcase
  endfunction

  logic req_sv39;
  logic req_canon;
  assign req_sv39  = (bus.satp[63:60] == MODE_SV39);
  assign req_canon = (bus.req_vaddr[63:39] == {25{bus.req_vaddr[38]}});

  logic [63:0] pte;
  logic [43:0] pte_ppn;
  logic        pte_leaf;
  logic        pte_fault;
  assign pte     = bus.mresp_data;
  assign pte_ppn = pte[53:10];

  always_comb begin
    pte_leaf  = pte[1] | pte[3];
    pte_fault = 1'b0;
    if (!pte[0] || (!pte[1] && pte[2])) begin
      pte_fault = 1'b1;
    end else if (pte_leaf) begin
      if (level == 2'd2 && pte_ppn[17:0] != 18'd0) pte_fault = 1'b1;
      if (level == 2'd1 && pte_ppn[8:0] != 9'd0)   pte_fault = 1'b1;
    end else if (level == 2'd0) begin
      pte_fault = 1'b1;
    end
  end

  logic [8:0] vpn_sel;
  always_comb begin
    case (level)
      2'd2:    vpn_sel = va[38:30];
      2'd1:    vpn_sel = va[29:21];
      default: vpn_sel = va[20:12];
    endcase
  end

  logic        tlb_hit;
  logic [55:0] hit_pa;
  logic        unused_bits;

`ifdef PTW_TLB_EN
  logic        tlb_valid;
  logic [15:0] tlb_asid;
  logic [26:0] tlb_vpn;
  logic [1:0]  tlb_level;
  logic [43:0] tlb_ppn;
  logic [15:0] asid_q;
  logic [26:0] req_vpn;
  logic        vpn_match;

  assign req_vpn = bus.req_vaddr[38:12];

  always_comb begin
    case (tlb_level)
      2'd2:    vpn_match = (tlb_vpn[26:18] == req_vpn[26:18]);
      2'd1:    vpn_match = (tlb_vpn[26:9] == req_vpn[26:9]);
      default: vpn_match = (tlb_vpn == req_vpn);
    endcase
    tlb_hit = tlb_valid && req_sv39 && req_canon && (tlb_asid == bus.satp[59:44]) && vpn_match;
  end

  assign hit_pa      = leaf_pa(tlb_ppn, tlb_level, bus.req_vaddr[29:0]);
  assign unused_bits = ^{pte[63:54], pte[9:4]};

  always_ff @(posedge clk) begin
    if (reset) begin
      asid_q <= 16'd0;
    end else if (state == IDLE && bus.req_valid) begin
      asid_q <= bus.satp[59:44];
    end
  end

  // Flush wins over a fill landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      tlb_valid <= 1'b0;
      if (reset) begin
        tlb_asid  <= 16'd0;
        tlb_vpn   <= 27'd0;
        tlb_level <= 2'd0;
        tlb_ppn   <= 44'd0;
      end
    end else if (state == WALK && bus.mresp_valid && pte_leaf && !pte_fault) begin
      tlb_valid <= 1'b1;
      tlb_asid  <= asid_q;
      tlb_vpn   <= va[38:12];
      tlb_level <= level;
      tlb_ppn   <= pte_ppn;
    end
  end
`else
  assign tlb_hit     = 1'b0;
  assign hit_pa      = 56'd0;
  assign unused_bits = ^{pte[63:54], pte[9:4], bus.satp[59:44], bus.flush};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      level   <= 2'd2;
      base    <= 44'd0;
      va      <= 39'd0;
      paddr_q <= 64'd0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            va <= bus.req_vaddr[38:0];
            if (!req_sv39) begin
              paddr_q <= {8'd0, bus.req_vaddr[55:0]};
              fault_q <= 1'b0;
              state   <= RESP;
            end else if (!req_canon) begin
              paddr_q <= 64'd0;
              fault_q <= 1'b1;
              state   <= RESP;
            end else if (tlb_hit) begin
              paddr_q <= {8'd0, hit_pa};
              fault_q <= 1'b0;
              state   <= RESP;
            end else begin
              level <= 2'd2;
              base  <= bus.satp[43:0];
              state <= WALK;
            end
          end
        end
        WALK: begin
          if (bus.mresp_valid) begin
            if (pte_fault) begin
              paddr_q <= 64'd0;
              fault_q <= 1'b1;
              state   <= RESP;
            end else if (pte_leaf) begin
              paddr_q <= {8'd0, leaf_pa(pte_ppn, level, va[29:0])};
              fault_q <= 1'b0;
              state   <= RESP;
            end else begin
              base  <= pte_ppn;
              level <= level - 2'd1;
            end
          end
        end
        RESP: begin
          level <= 2'd2;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_paddr = paddr_q;
  assign bus.resp_fault = fault_q;
  assign bus.mreq_valid = (state == WALK);
  assign bus.mreq_addr  = (state == WALK) ? {8'd0, base, vpn_sel, 3'b000} : 64'd0;
  assign bus.dbg_state  = state;
endmodule
